mul_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with HI/LO result registers. It sits directly downstream of the register file and consumes its two read ports (A, B) as operands for MULT/MULTU/DIV/DIVU. It also takes MTHI/MTLO writes from port A and holds HI/LO for MFHI/MFLO reads. The core is iterative, one bit per cycle, with a start/busy/done handshake so the control unit can stall while it runs.

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_div_step.sv | 19 +
 rtl/mul_div_unit.sv | 155 +++++++++++++++
 tb/tb_mul_div_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and op decode helpers.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, op, start, hi_we, lo_we,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  a, b, op, start, hi_we, lo_we,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_div_step.sv
// One combinational restoring-divide step: shift in the next dividend bit, trial-subtract the divisor.
module mul_div_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_q_bit,
  output logic [WIDTH-1:0] o_rem
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_trial;

  assign w_shift = {i_rem, i_bit};
  // Only taken when w_shift >= divisor, so the result always fits in WIDTH bits.
  assign w_trial = w_shift[WIDTH-1:0] - i_divisor;
  assign o_q_bit = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q_bit ? w_trial : w_shift[WIDTH-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 1-bit/cycle MULT/MULTU/DIV/DIVU with HI/LO registers; Start-to-Done is WIDTH+1 cycles, Start ignored while Busy.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; without it divide ops finish in one cycle and leave HI/LO untouched.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_step_next;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
  assign w_sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];
  assign w_a_mag  = w_sign_a ? -bus.a : bus.a;
  assign w_b_mag  = w_sign_b ? -bus.b : bus.b;

  // Shift-add: low half holds the unconsumed multiplier bits, high half the running sum.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  assign w_neg  = op_is_signed(r_op) & (r_sign_a ^ r_sign_b);
  assign w_prod = w_neg ? -r_acc : r_acc;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0]   r_b_mag;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_a_raw;

  mul_div_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit     (r_acc[WIDTH-1]),
    .i_divisor (r_b_mag),
    .o_q_bit   (w_q_bit),
    .o_rem     (w_rem_next)
  );

  assign w_step_next = op_is_div(r_op) ? {w_rem_next, r_acc[WIDTH-2:0], w_q_bit} : w_mul_next;
  assign w_quo       = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem       = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_a_raw     = r_sign_a ? -r_a_mag : r_a_mag;
`else
  assign w_step_next = w_mul_next;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_a_mag    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
      r_b_mag    <= '0;
`endif
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_a_mag  <= w_a_mag;
`ifdef MUL_DIV_UNIT_DIV_EN
            r_b_mag  <= w_b_mag;
`endif
            r_acc    <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? w_a_mag : w_b_mag)};
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
            r_state  <= ST_CALC;
`else
            r_state  <= op_is_div(bus.op) ? ST_FIX : ST_CALC;
`endif
          end else begin
            if (bus.hi_we) r_hi <= bus.a;
            if (bus.lo_we) r_lo <= bus.a;
          end
        end
        ST_CALC: begin
          r_acc <= w_step_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (!op_is_div(r_op)) begin
            r_hi       <= w_prod[2*WIDTH-1:WIDTH];
            r_lo       <= w_prod[WIDTH-1:0];
            r_div_zero <= 1'b0;
          end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
            // A zero divisor still runs the full loop; its result is overridden here.
            if (r_b_mag == '0) begin
              r_hi       <= w_a_raw;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else begin
              r_hi       <= w_rem;
              r_lo       <= w_quo;
              r_div_zero <= 1'b0;
            end
`else
            r_div_zero <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/DivZero/latency queued at Start, checked at Done.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) u_if ();

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.lat = 33;
    e.hi = m_hi;
    e.lo = m_lo;
    case (op)
      OP_MULT: begin
        p = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
`ifdef MUL_DIV_UNIT_DIV_EN
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
`else
        e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    m_hi = e.hi;
    m_lo = e.lo;
    sb_q.push_back(e);
    u_if.op = op;
    u_if.a = a;
    u_if.b = b;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.hi_we = 1'b0;
    u_if.lo_we = 1'b0;
  endtask

  task automatic wait_check(input string name, input int lat_in, input int bc_in);
    exp_t e;
    int lat, bc;
    lat = lat_in;
    bc = bc_in;
    while (u_if.done !== 1'b1 && lat < 100) begin
      if (u_if.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat); end
    n_tests++; if (bc !== e.lat) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, e.lat); end
    n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, u_if.busy); end
    n_tests++; if (u_if.hi !== e.hi) begin n_fail++; $display("FAIL %s hi: got %h want %h", name, u_if.hi, e.hi); end
    n_tests++; if (u_if.lo !== e.lo) begin n_fail++; $display("FAIL %s lo: got %h want %h", name, u_if.lo, e.lo); end
    n_tests++; if (u_if.div_zero !== e.dz) begin n_fail++; $display("FAIL %s div_zero: got %b want %b", name, u_if.div_zero, e.dz); end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_check(name, 0, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", name, u_if.busy); end
    n_tests++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b want 0", name, u_if.done); end
    n_tests++; if (u_if.div_zero !== 1'b0) begin n_fail++; $display("FAIL %s div_zero: got %b want 0", name, u_if.div_zero); end
    n_tests++; if (u_if.hi !== 32'd0) begin n_fail++; $display("FAIL %s hi: got %h want 0", name, u_if.hi); end
    n_tests++; if (u_if.lo !== 32'd0) begin n_fail++; $display("FAIL %s lo: got %h want 0", name, u_if.lo); end
  endtask

  task automatic test_reset();
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd4);
    run_op("div_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div_zero();
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0);
    run_op("multu_after_dz", OP_MULTU, 32'd3, 32'd5);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_rem_neg", OP_DIV, 32'd7, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mthi();
    logic [31:0] old_hi;
    u_if.a = 32'h0000_1234;
    u_if.hi_we = 1'b1;
    @(negedge clk);
    u_if.hi_we = 1'b0;
    m_hi = 32'h0000_1234;
    n_tests++; if (u_if.hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi: got %h want 00001234", u_if.hi); end
    u_if.a = 32'h0000_5678;
    u_if.lo_we = 1'b1;
    @(negedge clk);
    u_if.lo_we = 1'b0;
    m_lo = 32'h0000_5678;
    n_tests++; if (u_if.lo !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo: got %h want 00005678", u_if.lo); end
    // Start and HiWe together: the operation wins, HI keeps its value while busy.
    old_hi = m_hi;
    u_if.hi_we = 1'b1;
    issue(OP_MULTU, 32'h0000_0777, 32'd2);
    n_tests++; if (u_if.hi !== old_hi) begin n_fail++; $display("FAIL start_wins_hi: got %h want %h", u_if.hi, old_hi); end
    wait_check("start_wins_op", 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [31:0] old_hi, old_lo;
    int lat, bc, extra;
    old_hi = m_hi;
    old_lo = m_lo;
    issue(OP_MULTU, 32'd100, 32'd200);
    lat = 0;
    bc = 0;
    repeat (4) begin
      if (u_if.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    u_if.op = OP_MULTU;
    u_if.a = 32'h0000_DEAD;
    u_if.b = 32'd9;
    u_if.start = 1'b1;
    u_if.hi_we = 1'b1;
    u_if.lo_we = 1'b1;
    if (u_if.busy === 1'b1) bc++;
    @(negedge clk);
    lat++;
    u_if.start = 1'b0;
    u_if.hi_we = 1'b0;
    u_if.lo_we = 1'b0;
    n_tests++; if (u_if.hi !== old_hi) begin n_fail++; $display("FAIL busy_mthi: got %h want %h", u_if.hi, old_hi); end
    n_tests++; if (u_if.lo !== old_lo) begin n_fail++; $display("FAIL busy_mtlo: got %h want %h", u_if.lo, old_lo); end
    wait_check("busy_ignore", lat, bc);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.done === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_no_queue: got %0d extra done want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    u_if.op = OP_MULTU;
    u_if.a = 32'hFFFF_FFFF;
    u_if.b = 32'd3;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.done === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d done want 0", extra); end
    run_op("after_reset", OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    run_op("after_reset_div", OP_DIV, 32'd20, 32'hFFFF_FFFA);
  endtask

  initial begin
    rst_n = 1'b0;
    u_if.a = '0;
    u_if.b = '0;
    u_if.op = OP_MULT;
    u_if.start = 1'b0;
    u_if.hi_we = 1'b0;
    u_if.lo_we = 1'b0;
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_mthi();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
